// File: rtl/servidor_fila_cargo.sv
`default_nettype none
// ============================================================================
// Module      : servidor_fila_cargo
// Description : Consumer end of the SmartCargo request queue. Reads the head
//               entry, drives the elevator to the stop floor, holds the door
//               open, loads/unloads the cargo and pops the entry with shift.
// Revision    : 1.0 - initial release
// ============================================================================
module servidor_fila_cargo #(
   parameter int DOOR_CYCLES = 8,
   parameter int CNT_W       = 4
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             habilita,
   input  logic             head_eh_origem,
   input  logic [1:0]       head_tipo,
   input  logic [1:0]       head_origem,
   input  logic [1:0]       head_destino,
   input  logic [1:0]       andar_atual,
   output logic [3:0]       addr,
   output logic             shift,
   output logic [1:0]       andar_alvo,
   output logic             mover,
   output logic             porta_aberta,
   output logic             carga_valida,
   output logic [1:0]       carga_tipo,
   output logic             erro_carga,
   output logic [CNT_W-1:0] servidos,
   output logic [2:0]       estado_db
);

   // Door counter only has to hold DOOR_CYCLES-1 down to zero.
   localparam int                 DCNT_W    = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
   localparam logic [DCNT_W-1:0]  DOOR_LOAD = DCNT_W'(DOOR_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      MOVE   = 3'd1,
      DOOR   = 3'd2,
      POP    = 3'd3,
      SETTLE = 3'd4
   } state_t;

   state_t            state;
   logic              op_carga;   // 1 = pickup stop, 0 = unload stop
   logic [1:0]        tipo_reg;   // object type latched at acceptance
   logic [DCNT_W-1:0] door_cnt;
   logic [6:0]        head_entry;
   logic              head_valid;

   // An all-zero head entry marks an empty queue; origem only matters here.
   assign head_entry = {head_eh_origem, head_tipo, head_origem, head_destino};
   assign head_valid = |head_entry;

   // The head always sits at address 0.
   assign addr = 4'd0;

   // Motor and door are decoded straight from the state.
   assign mover        = (state == MOVE) && (andar_atual != andar_alvo);
   assign porta_aberta = (state == DOOR);
   assign estado_db    = state;

   // Service sequencer: accept, travel, door, pop, then wait for the RAM head.
   always_ff @(posedge clk) begin
      if (clear) begin
         state        <= IDLE;
         op_carga     <= 1'b0;
         tipo_reg     <= 2'd0;
         door_cnt     <= '0;
         andar_alvo   <= 2'd0;
         shift        <= 1'b0;
         carga_valida <= 1'b0;
         carga_tipo   <= 2'd0;
         erro_carga   <= 1'b0;
         servidos     <= '0;
      end else begin
         // shift and erro_carga are single-cycle pulses by default.
         shift      <= 1'b0;
         erro_carga <= 1'b0;
         case (state)
            IDLE: begin
               if (habilita && head_valid) begin
                  // Stop floor is always destino; pickups carry destino==origem.
                  andar_alvo <= head_destino;
                  op_carga   <= head_eh_origem;
                  tipo_reg   <= head_tipo;
                  state      <= MOVE;
               end
            end
            MOVE: begin
               if (andar_atual == andar_alvo) begin
                  door_cnt <= DOOR_LOAD;
                  state    <= DOOR;
               end
            end
            DOOR: begin
               if (door_cnt == '0) begin
                  if (op_carga) begin
                     if (carga_valida) begin
                        erro_carga <= 1'b1;
                     end else begin
                        carga_valida <= 1'b1;
                        carga_tipo   <= tipo_reg;
                     end
                  end else begin
                     if (carga_valida) begin
                        carga_valida <= 1'b0;
                        carga_tipo   <= 2'd0;
                     end else begin
                        erro_carga <= 1'b1;
                     end
                  end
                  // Registered so the pulse lines up with the POP state.
                  shift <= 1'b1;
                  state <= POP;
               end else begin
                  door_cnt <= door_cnt - DCNT_W'(1);
               end
            end
            POP: begin
               servidos <= servidos + CNT_W'(1);
               state    <= SETTLE;
            end
            SETTLE: begin
               // Gives the RAM one cycle to present the new head.
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_servidor_fila_cargo.sv
`default_nettype none
// ============================================================================
// Module      : tb_servidor_fila_cargo
// Description : Self-checking bench for servidor_fila_cargo. The bench plays
//               the queue RAM and the elevator; a cargo model predicts the
//               outcome of each served entry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servidor_fila_cargo;

   localparam int DOOR_CYCLES = 8;
   localparam int CNT_W       = 4;

   logic             clk = 1'b0;
   logic             clear;
   logic             habilita;
   logic             head_eh_origem;
   logic [1:0]       head_tipo;
   logic [1:0]       head_origem;
   logic [1:0]       head_destino;
   logic [1:0]       andar_atual;
   logic [3:0]       addr;
   logic             shift;
   logic [1:0]       andar_alvo;
   logic             mover;
   logic             porta_aberta;
   logic             carga_valida;
   logic [1:0]       carga_tipo;
   logic             erro_carga;
   logic [CNT_W-1:0] servidos;
   logic [2:0]       estado_db;

   int total = 0;
   int bad   = 0;

   // Cargo reference model and expected served count.
   logic       m_valid = 1'b0;
   logic [1:0] m_tipo  = 2'd0;
   int         exp_cnt = 0;

   logic prev_shift = 1'b0;
   logic prev_erro  = 1'b0;

   servidor_fila_cargo #(.DOOR_CYCLES(DOOR_CYCLES), .CNT_W(CNT_W)) dut (
      .clk(clk), .clear(clear), .habilita(habilita),
      .head_eh_origem(head_eh_origem), .head_tipo(head_tipo),
      .head_origem(head_origem), .head_destino(head_destino),
      .andar_atual(andar_atual), .addr(addr), .shift(shift),
      .andar_alvo(andar_alvo), .mover(mover), .porta_aberta(porta_aberta),
      .carga_valida(carga_valida), .carga_tipo(carga_tipo),
      .erro_carga(erro_carga), .servidos(servidos), .estado_db(estado_db)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   // Pulses must never last two cycles.
   always @(negedge clk) begin
      if (shift)      chk("shift_single_cycle", int'(prev_shift), 0);
      if (erro_carga) chk("erro_single_cycle", int'(prev_erro), 0);
      prev_shift <= shift;
      prev_erro  <= erro_carga;
   end

   task automatic check_reset(input string tag);
      chk({tag, "_estado"}, int'(estado_db), 0);
      chk({tag, "_shift"}, int'(shift), 0);
      chk({tag, "_alvo"}, int'(andar_alvo), 0);
      chk({tag, "_mover"}, int'(mover), 0);
      chk({tag, "_porta"}, int'(porta_aberta), 0);
      chk({tag, "_cvalid"}, int'(carga_valida), 0);
      chk({tag, "_ctipo"}, int'(carga_tipo), 0);
      chk({tag, "_erro"}, int'(erro_carga), 0);
      chk({tag, "_servidos"}, int'(servidos), 0);
      chk({tag, "_addr"}, int'(addr), 0);
   endtask

   // Cargo rules: returns the expected error pulse count and updates the model.
   function automatic int model_step(input logic eh, input logic [1:0] tp);
      if (eh) begin
         if (m_valid) return 1;
         m_valid = 1'b1; m_tipo = tp; return 0;
      end
      if (!m_valid) return 1;
      m_valid = 1'b0; m_tipo = 2'd0; return 0;
   endfunction

   // Present one entry at the head and follow it until the pop. Starts in the
   // posedge+1 phase of a cycle and ends on the negedge after the state
   // machine is back in IDLE.
   task automatic serve(input logic eh, input logic [1:0] tp, input logic [1:0] dst,
                        input logic [1:0] start, input int lag, input bit drop_hab,
                        output logic o_valid, output logic [1:0] o_tipo, output int o_err);
      int k, move_c, mov_c, door_c, err_c, lagc, shift_k, moves;
      bit done, mv;
      logic [2:0] st;
      k = 0; move_c = 0; mov_c = 0; door_c = 0; err_c = 0; lagc = 0; shift_k = -1;
      done = 0; o_valid = 1'b0; o_tipo = 2'd0;
      moves = (dst > start) ? int'(dst) - int'(start) : int'(start) - int'(dst);
      @(posedge clk); #1;
      head_eh_origem = eh;
      head_tipo      = tp;
      head_destino   = dst;
      head_origem    = eh ? dst : (dst ^ 2'($urandom_range(1, 3)));
      andar_atual    = start;
      habilita       = 1'b1;
      while (!done && k < 200) begin
         @(negedge clk);
         if (estado_db == 3'd1) move_c++;
         if (mover)        mov_c++;
         if (porta_aberta) door_c++;
         if (erro_carga)   err_c++;
         if (shift) begin
            done    = 1;
            shift_k = k;
            o_valid = carga_valida;
            o_tipo  = carga_tipo;
            chk("alvo_latched", int'(andar_alvo), int'(dst));
         end else begin
            mv = mover;
            st = estado_db;
            @(posedge clk); #1;
            if (k == 0) begin
               // Writer activity after acceptance must not disturb the stop.
               head_eh_origem = 1'($urandom);
               head_tipo      = 2'($urandom);
               head_origem    = 2'($urandom);
               head_destino   = 2'($urandom);
            end
            if (drop_hab && st == 3'd1) habilita = 1'b0;
            if (st == 3'd2) begin
               andar_atual = 2'($urandom);
            end else if (mv) begin
               lagc++;
               if (lagc >= lag) begin
                  lagc = 0;
                  if (andar_atual < dst) andar_atual = andar_atual + 2'd1;
                  else if (andar_atual > dst) andar_atual = andar_atual - 2'd1;
               end
            end
            k++;
         end
      end
      chk("shift_seen", int'(done), 1);
      chk("door_cycles", door_c, DOOR_CYCLES);
      chk("mover_cycles", mov_c, moves * lag);
      chk("move_state_cycles", move_c, moves * lag + 1);
      chk("shift_latency", shift_k, moves * lag + DOOR_CYCLES + 2);
      o_err = err_c;
      @(posedge clk); #1;
      habilita       = 1'b0;
      head_eh_origem = 1'b0; head_tipo = 2'd0; head_origem = 2'd0; head_destino = 2'd0;
      exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
      @(negedge clk);
      chk("settle_state", int'(estado_db), 4);
      chk("servidos", int'(servidos), exp_cnt);
      @(negedge clk);
      chk("back_idle", int'(estado_db), 0);
   endtask

   typedef struct {
      logic       eh;
      logic [1:0] tipo;
      logic [1:0] dst;
      logic [1:0] start;
      int         lag;
      logic       e_valid;
      logic [1:0] e_tipo;
      int         e_err;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic       ov;
      logic [1:0] ot;
      int         oe, ee, dc, sh, cnt_bad;
      logic       reh;
      logic [1:0] rtp, rdst, rst_f;

      vecs[0] = '{1'b1, 2'd2, 2'd1, 2'd0, 3, 1'b1, 2'd2, 0}; // pickup, 3 mover cycles
      vecs[1] = '{1'b0, 2'd2, 2'd3, 2'd1, 2, 1'b0, 2'd0, 0}; // unload at floor 3
      vecs[2] = '{1'b0, 2'd1, 2'd2, 2'd2, 1, 1'b0, 2'd0, 1}; // unload, empty, at floor
      vecs[3] = '{1'b1, 2'd1, 2'd2, 2'd3, 1, 1'b1, 2'd1, 0}; // pickup type 1
      vecs[4] = '{1'b1, 2'd3, 2'd0, 2'd2, 2, 1'b1, 2'd1, 1}; // second pickup -> error
      vecs[5] = '{1'b0, 2'd1, 2'd0, 2'd0, 1, 1'b0, 2'd0, 0}; // unload at floor 0

      clear = 1'b1; habilita = 1'b0; andar_atual = 2'd0;
      head_eh_origem = 1'b0; head_tipo = 2'd0; head_origem = 2'd0; head_destino = 2'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset("reset");

      // Empty queue with habilita held high.
      @(posedge clk); #1;
      clear = 1'b0; habilita = 1'b1;
      cnt_bad = 0; sh = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (estado_db != 3'd0) cnt_bad++;
         if (shift) sh++;
      end
      chk("empty_stays_idle", cnt_bad, 0);
      chk("empty_no_shift", sh, 0);
      chk("empty_servidos", int'(servidos), 0);

      // Directed vectors.
      for (int i = 0; i < 6; i++) begin
         serve(vecs[i].eh, vecs[i].tipo, vecs[i].dst, vecs[i].start, vecs[i].lag, 1'b0, ov, ot, oe);
         chk($sformatf("vec%0d_cvalid", i), int'(ov), int'(vecs[i].e_valid));
         chk($sformatf("vec%0d_ctipo", i), int'(ot), int'(vecs[i].e_tipo));
         chk($sformatf("vec%0d_erro", i), oe, vecs[i].e_err);
      end
      m_valid = vecs[5].e_valid;
      m_tipo  = vecs[5].e_tipo;

      // Load something so that clear has visible state to wipe.
      ee = model_step(1'b1, 2'd3);
      serve(1'b1, 2'd3, 2'd1, 2'd1, 1, 1'b0, ov, ot, oe);
      chk("preclr_cvalid", int'(ov), int'(m_valid));
      chk("preclr_erro", oe, ee);

      // Clear in the fourth door cycle of an unload stop.
      @(posedge clk); #1;
      head_eh_origem = 1'b0; head_tipo = 2'd3; head_origem = 2'd0; head_destino = 2'd2;
      andar_atual = 2'd0; habilita = 1'b1;
      dc = 0; sh = 0;
      for (int k = 0; k < 100 && dc < 4; k++) begin
         @(negedge clk);
         if (porta_aberta) dc++;
         if (shift) sh++;
         if (dc < 4) begin
            ov = mover;
            @(posedge clk); #1;
            if (ov && andar_atual < 2'd2) andar_atual = andar_atual + 2'd1;
         end
      end
      chk("clr_door_reached", dc, 4);
      clear = 1'b1;
      @(negedge clk);
      check_reset("midclr");
      chk("midclr_no_shift", sh, 0);
      @(posedge clk); #1;
      clear = 1'b0; habilita = 1'b0;
      m_valid = 1'b0; m_tipo = 2'd0; exp_cnt = 0;
      ee = model_step(1'b0, 2'd3);
      serve(1'b0, 2'd3, 2'd2, 2'd0, 1, 1'b0, ov, ot, oe);
      chk("reserve_cvalid", int'(ov), int'(m_valid));
      chk("reserve_erro", oe, ee);

      // habilita dropped during MOVE: entry completes, then block stays idle.
      ee = model_step(1'b1, 2'd2);
      serve(1'b1, 2'd2, 2'd3, 2'd0, 2, 1'b1, ov, ot, oe);
      chk("drop_cvalid", int'(ov), int'(m_valid));
      chk("drop_ctipo", int'(ot), int'(m_tipo));
      chk("drop_erro", oe, ee);
      @(posedge clk); #1;
      head_eh_origem = 1'b0; head_tipo = 2'd1; head_origem = 2'd0; head_destino = 2'd1;
      cnt_bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (estado_db != 3'd0 || shift) cnt_bad++;
      end
      chk("hab_low_stays_idle", cnt_bad, 0);

      // Randomized service against the cargo model, wrapping the counter.
      @(posedge clk); #1;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      head_eh_origem = 1'b0; head_tipo = 2'd0; head_origem = 2'd0; head_destino = 2'd0;
      m_valid = 1'b0; m_tipo = 2'd0; exp_cnt = 0;
      @(negedge clk);
      for (int i = 0; i < 30; i++) begin
         reh   = 1'($urandom);
         rtp   = 2'($urandom);
         rdst  = 2'($urandom);
         rst_f = 2'($urandom);
         ee = model_step(reh, rtp);
         serve(reh, rtp, rdst, rst_f, int'($urandom_range(1, 3)), 1'($urandom), ov, ot, oe);
         chk($sformatf("rnd%0d_cvalid", i), int'(ov), int'(m_valid));
         chk($sformatf("rnd%0d_ctipo", i), int'(ot), int'(m_tipo));
         chk($sformatf("rnd%0d_erro", i), oe, ee);
         if (i == 16) chk("wrap_17_served", int'(servidos), 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/servidor_fila_cargo.md
Name: servidor_fila_cargo

Overview:
- Consumer end of the SmartCargo request queue. The queue RAM is the writer side: weT/fit insert entries, the head sits at address 0, and shift pops the head.
- This block reads the head entry, drives the elevator to the stop floor, holds the door open, loads or unloads the cargo, then pulses shift to pop the entry.
- It sits between the queue RAM outputs and the elevator motor/door logic.

Parameters:
- DOOR_CYCLES, 8, clock cycles porta_aberta stays high per stop (>=1).
- CNT_W, 4, width of the served-entries counter.

Ports:
- clk  in  1  system clock
- clear  in  1  synchronous active-high reset
- habilita  in  1  allows a new entry to be taken in IDLE
- head_eh_origem  in  1  RAM eh_origem output for addr 0 (1 = pickup stop)
- head_tipo  in  2  RAM tipo_objeto output
- head_origem  in  2  RAM origem_objeto output
- head_destino  in  2  RAM destino_objeto output
- andar_atual  in  2  current elevator floor
- addr  out  4  RAM read address, constant 4'd0
- shift  out  1  one-cycle pop pulse to RAM
- andar_alvo  out  2  floor the elevator must reach
- mover  out  1  motor request, high while in MOVE and andar_atual != andar_alvo
- porta_aberta  out  1  door open
- carga_valida  out  1  elevator holds an object
- carga_tipo  out  2  type of the held object
- erro_carga  out  1  one-cycle pulse on an inconsistent load or unload
- servidos  out  CNT_W  entries popped since reset, wraps modulo 2^CNT_W
- estado_db  out  3  state encoding for debug display

Behaviour:
- Head entry: head_entry = {head_eh_origem, head_tipo, head_origem, head_destino}. head_entry == 7'b0 means the queue is empty.
- RAM read latency: RAM outputs follow addr through a registered address. Because addr is constant 0, the head is valid from the second cycle after clear. After shift, the new head is valid one cycle after the shift edge; the SETTLE state covers this.
- Reset (clear=1 at a clk edge): state=IDLE, addr=0, shift=0, andar_alvo=0, mover=0, porta_aberta=0, carga_valida=0, carga_tipo=0, erro_carga=0, servidos=0.
- Clear mid-operation aborts immediately: no shift is issued and the entry stays in the queue.
- States and encodings: IDLE=0, MOVE=1, DOOR=2, POP=3, SETTLE=4.
- IDLE:
  - If habilita=1 and head_entry != 0: latch andar_alvo<=head_destino, op_carga<=head_eh_origem, tipo_reg<=head_tipo, then go to MOVE.
  - Otherwise stay in IDLE.
  - head_origem is not used for routing; the stop floor is always head_destino. Pickup entries carry destino==origem.
- MOVE:
  - mover = (andar_atual != andar_alvo), combinational from state.
  - When andar_atual == andar_alvo: load the door counter with DOOR_CYCLES-1 and go to DOOR.
  - If the elevator is already at the target, MOVE lasts exactly 1 cycle with mover=0.
- DOOR:
  - porta_aberta=1 for exactly DOOR_CYCLES cycles; the counter decrements each cycle.
  - On the cycle the counter reads 0, update cargo and go to POP.
  - Pickup (op_carga=1) with carga_valida=0: carga_valida<=1, carga_tipo<=tipo_reg.
  - Pickup with carga_valida=1: erro_carga pulses, cargo is unchanged.
  - Unload (op_carga=0) with carga_valida=1: carga_valida<=0, carga_tipo<=0.
  - Unload with carga_valida=0: erro_carga pulses.
  - The entry is popped in every case.
- POP: shift=1 for this single cycle, servidos<=servidos+1, then go to SETTLE.
- SETTLE: all outputs idle for one cycle, then go to IDLE. This prevents re-reading the stale head.
- habilita is sampled only in IDLE. Dropping it mid-service lets the current entry finish.
- andar_atual changing while in DOOR is ignored.
- Latched fields are stable from the IDLE->MOVE edge until the next acceptance. Head changes caused by writer fit/weT during service do not affect the current stop.
- shift never asserts in two consecutive cycles. Minimum service time for one entry is 1+DOOR_CYCLES+1+1 cycles after acceptance.
- Outputs are registered except mover and porta_aberta, which are decoded from state.

Test Plan:
- Reset and empty queue: clear, then habilita=1 with head=0 for 20 cycles -> state stays IDLE (estado_db=0), shift never asserts, servidos=0.
- Pickup then unload:
  - Stimulus: head={1,2'b10,2'b01,2'b01}, andar_atual=0, advanced to 1 after 3 cycles of mover.
  - Pickup response: mover high while andar_atual=0, drops when andar_atual=1; porta_aberta high for exactly 8 cycles; carga_valida=1, carga_tipo=2; one shift pulse; servidos=1.
  - Next head={0,2'b10,2'b01,2'b11}, elevator moved to floor 3 -> carga_valida=0, servidos=2, erro_carga never pulses.
- Already at floor: andar_atual=2, head destino=2 -> MOVE lasts 1 cycle with mover=0; shift follows at acceptance+1+DOOR_CYCLES+1 cycles.
- Errors: unload entry with carga_valida=0 -> erro_carga one pulse, entry still popped. Two consecutive pickups -> erro_carga on the second, carga_tipo keeps the first value.
- Clear during DOOR on cycle 4 -> all outputs return to reset values next cycle, shift never asserts, and the same head is served again after clear.
- Wrap and habilita: 17 entries served -> servidos reads 1. Deasserting habilita during MOVE -> the entry completes, then the block stays in IDLE with a nonzero head.
